// File: rtl/imem_loader_ctrl_pkg.sv
// imem_loader_ctrl shared types and defaults.
// Holds the controller state encoding plus the DEPTH and NOP defaults.
package imem_loader_ctrl_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int          DEPTH_DEF = 64;
  localparam logic [31:0] NOP_DEF   = 32'hE1A00000;

endpackage

// File: rtl/imem_ram.sv
// imem_ram: DEPTH x 32 instruction storage.
// One synchronous write port, one asynchronous read port, no reset.
module imem_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // write the loader word on the accepting edge
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: sequences instruction memory between loader and fetch.
// Optional XOR load checksum enabled by defining IMEM_CKSUM_EN.
module imem_loader_ctrl
  import imem_loader_ctrl_pkg::*;
#(
  parameter int          DEPTH = DEPTH_DEF,
  parameter int          AW    = $clog2(DEPTH),
  parameter logic [31:0] NOP   = NOP_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   a,
  output logic [31:0]   rd,
  output logic          cpu_stall,
  input  logic          ld_start,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          load_done,
  output logic [AW:0]   wcount,
  output logic          fetch_fault,
  output logic [31:0]   cksum
);

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] waddr_q;
  logic [AW:0]   wcount_q;
  logic          fault_q;
  logic [31:0]   ram_rd;
  logic          acc;
  logic          in_rng;
  logic          last_w;
  logic          unused;

  assign unused = ^a[1:0];
  assign in_rng = a[31:2] < 30'(DEPTH);
  assign acc    = ld_valid & (state_q == LOAD) & ~ld_start;
  assign last_w = ld_last | (waddr_q == AW'(DEPTH - 1));

  imem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (acc),
    .waddr (waddr_q),
    .wdata (ld_data),
    .raddr (a[AW+1:2]),
    .rdata (ram_rd)
  );

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= LOAD;
    else        state_q <= state_d;
  end

  // next state and mode-dependent outputs
  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b1;
    ld_ready  = 1'b0;
    load_done = 1'b0;
    rd        = NOP;
    unique case (state_q)
      LOAD: begin
        ld_ready = 1'b1;
        if (acc && last_w) state_d = RUN;
      end
      RUN: begin
        cpu_stall = 1'b0;
        load_done = 1'b1;
        if (in_rng) rd = ram_rd;
      end
      default: state_d = LOAD;
    endcase
    if (ld_start) state_d = LOAD;
  end

  // write pointer, saturating word count and sticky fault flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waddr_q  <= '0;
      wcount_q <= '0;
      fault_q  <= 1'b0;
    end else if (ld_start) begin
      waddr_q  <= '0;
      wcount_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      if (acc) begin
        waddr_q <= waddr_q + 1'b1;
        if (wcount_q != (AW+1)'(DEPTH))
          wcount_q <= wcount_q + 1'b1;
      end
      if (state_q == RUN && !in_rng)
        fault_q <= 1'b1;
    end
  end

  assign wcount      = wcount_q;
  assign fetch_fault = fault_q;

`ifdef IMEM_CKSUM_EN
  logic [31:0] cksum_q;

  // XOR every accepted word into the checksum
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        cksum_q <= '0;
    else if (ld_start) cksum_q <= '0;
    else if (acc)      cksum_q <= cksum_q ^ ld_data;
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule

// File: doc/imem_loader_ctrl.md
# imem_loader_ctrl

Controller that owns the instruction memory and sequences it between a boot/program loader and the processor fetch port. After reset it holds the CPU stalled while a loader streams words into consecutive memory locations. It then hands the memory to the fetch port for run mode. It also handles reload requests, out-of-range fetches and an optional load checksum. It sits between the board-level loader (UART/switch front end) and the core's instruction fetch.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit instruction words
- AW, $clog2(DEPTH), word-address width (derived)
- NOP, 32'hE1A00000, instruction returned while stalled or on an out-of-range fetch

Ports:
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low reset
- a  input  32  CPU fetch byte address; word index = a[31:2]
- rd  output  32  fetched instruction
- cpu_stall  output  1  high while the CPU must not advance its PC
- ld_start  input  1  one-cycle pulse: begin a (re)load
- ld_valid  input  1  loader word valid
- ld_ready  output  1  controller accepts a word this cycle
- ld_data  input  32  loader word
- ld_last  input  1  marks the final word of the image, qualified by ld_valid
- load_done  output  1  high in RUN
- wcount  output  AW+1  number of words written by the current or last load
- fetch_fault  output  1  sticky flag: an out-of-range fetch occurred in RUN
- cksum  output  32  XOR checksum of loaded words (see Configuration)

## Operation
- States: LOAD, RUN. Reset enters LOAD.
- **LOAD**
  - cpu_stall=1, ld_ready=1, rd=NOP.
  - A word is accepted on a cycle with ld_valid&ld_ready: RAM[waddr]<=ld_data, then waddr and wcount increment.
  - Transition to RUN when the accepted word has ld_last=1, or when waddr==DEPTH-1. Further words are refused (ld_ready=0).
- **RUN**
  - cpu_stall=0, ld_ready=0.
  - rd=RAM[a[31:2]] combinationally when a[31:2]<DEPTH. Otherwise rd=NOP and fetch_fault is set.
  - fetch_fault clears only on reset or ld_start.
- ld_start, in either state:
  - Enters LOAD.
  - waddr=0, wcount=0, fetch_fault=0, cksum=0.
  - RAM contents are retained; they are overwritten as new words arrive.
- ld_start and an accepted word in the same cycle: ld_start wins and the word is dropped.
- ld_valid in RUN is ignored. Memory is never written in RUN.
- Reset mid-load: state returns to LOAD with counters cleared. RAM contents are undefined/retained (not cleared).

## Timing
- Reset values:
  - Asserted outputs: cpu_stall=1, ld_ready=1, rd=NOP.
  - Cleared outputs: load_done=0, wcount=0, fetch_fault=0, cksum=0.
- Fetch read has zero latency (combinational from a) in RUN.
- Write latency: data is visible to fetch the cycle after the accepting edge.
- Last word accepted at edge N gives state RUN from edge N onward: cpu_stall=0 and load_done=1 in cycle N+1.
- ld_start sampled at edge N gives cpu_stall=1 in cycle N+1. The instruction fetched in cycle N is still valid data.
- wcount saturates at DEPTH; there is no wrap-around.

## Configuration
- IMEM_CKSUM_EN defined:
  - cksum accumulates cksum^ld_data on every accepted word.
  - cksum holds its value in RUN and clears on ld_start and on reset.
- Undefined: cksum is tied to 0 and the accumulator logic is absent.

## Structure
- Shared package holds:
  - state enum {LOAD, RUN};
  - the NOP constant default;
  - the DEPTH default.
- One sub-module, imem_ram:
  - DEPTH×32 storage;
  - synchronous write port (we, waddr, wdata);
  - asynchronous read port (raddr, rdata).
- The controller instantiates imem_ram and contains the FSM, counters, fault flag and checksum.

## Test plan
- Reset, then load 3 words (0xE04F000F, 0xF0813032, 0xF0423021) with ld_last on the third → cpu_stall falls the cycle after, load_done=1, wcount=3; a=0x8 gives rd=0xF0423021.
- Stream 64 words with ld_last never asserted → auto RUN after word 64, wcount=64, ld_ready=0; a 65th ld_valid is ignored and RAM[0] is unchanged.
- In RUN, a=0x100 → rd=NOP (0xE1A00000) and fetch_fault=1; a=0x4 afterwards gives valid data and fetch_fault stays 1 until ld_start.
- In RUN, pulse ld_start → cpu_stall=1 next cycle, wcount=0; reload 1 word 0x12345678 → a=0x0 gives 0x12345678, and old word 1 remains readable at a=0x4.
- Assert reset mid-load after 2 words → all outputs return to reset values asynchronously, and the next load restarts at address 0.
- With IMEM_CKSUM_EN, load 0xF0F0F0F0 and 0x0F0F0F0F → cksum=0xFFFFFFFF. Without the macro, cksum=0.
